// File: rtl/top_memory_access.sv
// Memory-access stage: issues data-memory loads/stores over a req/ack bus and latches results for writeback.
// Optional MEMACC_MISALIGN_TRAP_EN: misaligned accesses become flagged no-ops instead of being force-aligned.

module memacc_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] a_lo,
  input  logic [7:0] b_byte,
  input  logic [7:0] b_half,
  input  logic [7:0] b_word,
  output logic       be,
  output logic [7:0] wdata
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    be    = 1'b1;
    wdata = b_word;
    case (size)
      2'b00: begin
        be    = (a_lo == L);
        wdata = b_byte;
      end
      2'b01: begin
        be    = (a_lo[1] == L[1]);
        wdata = b_half;
      end
      default: begin
        be    = 1'b1;
        wdata = b_word;
      end
    endcase
  end
endmodule

module top_memory_access #(
  parameter int XLEN      = 32,
  parameter int OPLEN     = 8,
  parameter int LOAD_BIT  = 0,
  parameter int STORE_BIT = 1,
  parameter int SIZE_LSB  = 2,
  parameter int UNS_BIT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_memoryaccess,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [XLEN-1:0]  rs2data_em,
  input  logic             jump_state_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ack,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic             jump_state_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  load_data_mw,
  output logic             misalign_err_mw,
  output logic             stall_memoryaccess
);
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e state_q, state_d;

  logic                 is_load, is_store, memop, uns, trapped, issue_ok, latch_en;
  logic [1:0]           size, a_lo;
  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic            ld_load_q, ld_load_d, ld_uns_q, ld_uns_d;
  logic [1:0]      ld_size_q, ld_size_d, ld_alo_q, ld_alo_d;
  logic [XLEN-1:0] ld_shift, ld_ext;

  logic [OPLEN-1:0] op_mw_q, op_mw_d;
  logic [4:0]       rd_mw_q, rd_mw_d;
  logic [XLEN-1:0]  npc_mw_q, npc_mw_d, alu_mw_q, alu_mw_d, ld_mw_q, ld_mw_d;
  logic             jmp_mw_q, jmp_mw_d;

  assign is_load  = decoded_op_em[LOAD_BIT];
  assign is_store = decoded_op_em[STORE_BIT];
  assign uns      = decoded_op_em[UNS_BIT];
  assign size     = decoded_op_em[SIZE_LSB +: 2];
  assign memop    = is_load | is_store;

  // Low address bits snapped to natural alignment; a trapped access never uses them.
  always_comb begin
    a_lo = alu_out_em[1:0];
    if (size == 2'b01)  a_lo = {alu_out_em[1], 1'b0};
    else if (size[1])   a_lo = 2'b00;
  end

`ifdef MEMACC_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_mw_q, err_mw_d;
  assign misaligned = ((size == 2'b01) && alu_out_em[0]) ||
                      (size[1] && (alu_out_em[1:0] != 2'b00));
  assign trapped    = memop & misaligned;
`else
  assign trapped    = 1'b0;
`endif

  assign issue_ok           = memop & ~trapped;
  assign stall_memoryaccess = phase_memoryaccess &
                              (((state_q == IDLE) & issue_ok) | (state_q == BUSY));
  assign latch_en           = phase_memoryaccess & ~stall_memoryaccess;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    memacc_lane #(.LANE(i)) u_lane (
      .size   (size),
      .a_lo   (a_lo),
      .b_byte (rs2data_em[7:0]),
      .b_half (rs2data_em[8*(i%2) +: 8]),
      .b_word (rs2data_em[8*i +: 8]),
      .be     (lane_be[i]),
      .wdata  (lane_wdata[i])
    );
  end

  // DONE waits for phase so a completed transaction is latched exactly once,
  // even if the state machine dropped phase while the bus was busy.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    ld_load_d = ld_load_q;
    ld_uns_d  = ld_uns_q;
    ld_size_d = ld_size_q;
    ld_alo_d  = ld_alo_q;
    case (state_q)
      IDLE: begin
        if (phase_memoryaccess && issue_ok) begin
          state_d   = BUSY;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {alu_out_em[XLEN-1:2], 2'b00};
          wdata_d   = lane_wdata;
          be_d      = lane_be;
          ld_load_d = is_load;
          ld_uns_d  = uns;
          ld_size_d = size;
          ld_alo_d  = a_lo;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = dmem_rdata;
        end
      end
      DONE: begin
        if (phase_memoryaccess) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_shift = rdata_q >> {ld_alo_q, 3'b000};
    ld_ext   = rdata_q;
    case (ld_size_q)
      2'b00:   ld_ext = ld_uns_q ? {{(XLEN-8){1'b0}}, ld_shift[7:0]}
                                 : {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = ld_uns_q ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                 : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = rdata_q;
    endcase
  end

  always_comb begin
    op_mw_d  = op_mw_q;
    rd_mw_d  = rd_mw_q;
    npc_mw_d = npc_mw_q;
    jmp_mw_d = jmp_mw_q;
    alu_mw_d = alu_mw_q;
    ld_mw_d  = ld_mw_q;
    if (latch_en) begin
      op_mw_d  = decoded_op_em;
      rd_mw_d  = rdsel_em;
      npc_mw_d = next_pc_em;
      jmp_mw_d = jump_state_em;
      alu_mw_d = alu_out_em;
      ld_mw_d  = ((state_q == DONE) && ld_load_q) ? ld_ext : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      ld_load_q <= 1'b0;
      ld_uns_q  <= 1'b0;
      ld_size_q <= '0;
      ld_alo_q  <= '0;
      op_mw_q   <= '0;
      rd_mw_q   <= '0;
      npc_mw_q  <= '0;
      jmp_mw_q  <= 1'b0;
      alu_mw_q  <= '0;
      ld_mw_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      ld_load_q <= ld_load_d;
      ld_uns_q  <= ld_uns_d;
      ld_size_q <= ld_size_d;
      ld_alo_q  <= ld_alo_d;
      op_mw_q   <= op_mw_d;
      rd_mw_q   <= rd_mw_d;
      npc_mw_q  <= npc_mw_d;
      jmp_mw_q  <= jmp_mw_d;
      alu_mw_q  <= alu_mw_d;
      ld_mw_q   <= ld_mw_d;
    end
  end

`ifdef MEMACC_MISALIGN_TRAP_EN
  always_comb begin
    err_mw_d = err_mw_q;
    if (latch_en) err_mw_d = trapped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_mw_q <= 1'b0;
    else        err_mw_q <= err_mw_d;
  end

  assign misalign_err_mw = err_mw_q;
`else
  assign misalign_err_mw = 1'b0;
`endif

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign decoded_op_mw = op_mw_q;
  assign rdsel_mw      = rd_mw_q;
  assign next_pc_mw    = npc_mw_q;
  assign jump_state_mw = jmp_mw_q;
  assign alu_out_mw    = alu_mw_q;
  assign load_data_mw  = ld_mw_q;
endmodule
